// File: rtl/decoder_select_sequencer.sv
// Select sequencer driving the 2-to-4 active-low decoder stage.
// Ports: clk/rst, en, mode, dwell, mask, step_req -> step_ack, s1:s0, sel_valid, frame_done.
module decoder_select_sequencer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [3:0]         mask,
  input  logic               step_req,
  output logic               step_ack,
  output logic               s0,
  output logic               s1,
  output logic               sel_valid,
  output logic               frame_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    STEP = 2'd2
  } state_t;

  state_t             state, state_d;
  logic [1:0]         idx, idx_d;
  logic [DWELL_W-1:0] cnt, cnt_d;
  logic               valid_d, ack_d, frame_d;

  logic [1:0] nxt, low, cand;
  logic       wrap;
  logic       all_masked;

  assign all_masked = &mask;

  // Descending search so the smallest offset wins; offset 4 lands back
  // on idx itself, covering the single-unmasked-line case.
  always_comb begin
    nxt  = idx;
    cand = idx;
    for (int i = 4; i >= 1; i--) begin
      cand = idx + i[1:0];
      if (!mask[cand]) nxt = cand;
    end
    wrap = (nxt <= idx);
  end

  always_comb begin
    low = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!mask[i]) low = i[1:0];
    end
  end

  always_comb begin
    state_d = state;
    idx_d   = idx;
    cnt_d   = cnt;
    valid_d = sel_valid;
    ack_d   = 1'b0;
    frame_d = 1'b0;
    if (!en) begin
      state_d = IDLE;
      valid_d = 1'b0;
      cnt_d   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          valid_d = 1'b0;
          if (!all_masked) begin
            idx_d   = low;
            valid_d = 1'b1;
            cnt_d   = '0;
            state_d = mode ? STEP : SCAN;
          end
        end
        SCAN, STEP: begin
          if (all_masked) begin
            state_d = IDLE;
            valid_d = 1'b0;
            cnt_d   = '0;
          end else if (mask[idx]) begin
            // Current line just got masked: leave it immediately.
            idx_d   = nxt;
            frame_d = wrap;
            cnt_d   = '0;
          end else if (mode != (state == STEP)) begin
            state_d = mode ? STEP : SCAN;
            cnt_d   = '0;
          end else if (state == SCAN) begin
            if (cnt >= dwell) begin
              idx_d   = nxt;
              frame_d = wrap;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt + 1'b1;
            end
          end else begin
            // A request is only taken when no ack is pending, so a held
            // request yields one step every two cycles.
            if (step_req && !step_ack) begin
              idx_d   = nxt;
              ack_d   = 1'b1;
              frame_d = wrap;
            end
          end
        end
        default: begin
          state_d = IDLE;
          valid_d = 1'b0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= 2'd0;
      cnt        <= '0;
      sel_valid  <= 1'b0;
      step_ack   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      idx        <= idx_d;
      cnt        <= cnt_d;
      sel_valid  <= valid_d;
      step_ack   <= ack_d;
      frame_done <= frame_d;
    end
  end

  assign s1 = idx[1];
  assign s0 = idx[0];

endmodule

// File: tb/tb_decoder_select_sequencer.sv
// Directed self-checking bench for decoder_select_sequencer.
// Vector table plus hand-written multi-cycle sequences.
module tb_decoder_select_sequencer;

  logic       clk = 1'b0;
  logic       rst, en, mode, step_req;
  logic [7:0] dwell;
  logic [3:0] mask;
  logic       step_ack, s0, s1, sel_valid, frame_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decoder_select_sequencer #(.DWELL_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .mode       (mode),
    .dwell      (dwell),
    .mask       (mask),
    .step_req   (step_req),
    .step_ack   (step_ack),
    .s0         (s0),
    .s1         (s1),
    .sel_valid  (sel_valid),
    .frame_done (frame_done)
  );

  typedef struct {
    string      name;
    logic       rst;
    logic       en;
    logic       mode;
    logic [7:0] dwell;
    logic [3:0] mask;
    logic       req;
    logic [1:0] s;
    logic       v;
    logic       a;
    logic       f;
  } vec_t;

  vec_t vq[$];

  task automatic add(input string n, input logic r, input logic e,
                     input logic m, input logic [7:0] d,
                     input logic [3:0] mk, input logic rq,
                     input logic [1:0] s, input logic v,
                     input logic a, input logic f);
    vec_t t;
    t.name = n; t.rst = r; t.en = e; t.mode = m; t.dwell = d;
    t.mask = mk; t.req = rq; t.s = s; t.v = v; t.a = a; t.f = f;
    vq.push_back(t);
  endtask

  task automatic drive(input logic r, input logic e, input logic m,
                       input logic [7:0] d, input logic [3:0] mk,
                       input logic rq);
    rst = r; en = e; mode = m; dwell = d; mask = mk; step_req = rq;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string n, input logic [1:0] s,
                            input logic v, input logic a,
                            input logic f);
    logic [4:0] got, want;
    got  = {s1, s0, sel_valid, step_ack, frame_done};
    want = {s, v, a, f};
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got s=%b%b valid=%b ack=%b frame=%b want s=%b valid=%b ack=%b frame=%b",
               n, s1, s0, sel_valid, step_ack, frame_done, s, v, a, f);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 1'b0; dwell = 8'd0;
    mask = 4'b0000; step_req = 1'b0;

    // reset
    add("rst0", 1, 0, 0, 8'd2, 4'b0000, 0, 2'b00, 0, 0, 0);
    add("rst1", 1, 0, 0, 8'd2, 4'b0000, 0, 2'b00, 0, 0, 0);
    // auto-scan, dwell=2: three cycles per line
    for (int i = 0; i < 12; i++)
      add("scan", 0, 1, 0, 8'd2, 4'b0000, 0, 2'(i / 3), 1, 0, 0);
    add("scan_wrap", 0, 1, 0, 8'd2, 4'b0000, 0, 2'b00, 1, 0, 1);
    add("scan_after", 0, 1, 0, 8'd2, 4'b0000, 0, 2'b00, 1, 0, 0);
    // mask 0101, dwell=0: forced off line 0 first
    add("skip_force", 0, 1, 0, 8'd0, 4'b0101, 0, 2'b01, 1, 0, 0);
    add("skip_11a", 0, 1, 0, 8'd0, 4'b0101, 0, 2'b11, 1, 0, 0);
    add("skip_01a", 0, 1, 0, 8'd0, 4'b0101, 0, 2'b01, 1, 0, 1);
    add("skip_11b", 0, 1, 0, 8'd0, 4'b0101, 0, 2'b11, 1, 0, 0);
    add("skip_01b", 0, 1, 0, 8'd0, 4'b0101, 0, 2'b01, 1, 0, 1);
    add("dis", 0, 0, 0, 8'd0, 4'b0101, 0, 2'b01, 0, 0, 0);
    // single-step
    add("step_entry", 0, 1, 1, 8'd0, 4'b0000, 0, 2'b00, 1, 0, 0);
    add("step_idle", 0, 1, 1, 8'd0, 4'b0000, 0, 2'b00, 1, 0, 0);
    add("step1", 0, 1, 1, 8'd0, 4'b0000, 1, 2'b01, 1, 1, 0);
    add("step2", 0, 1, 1, 8'd0, 4'b0000, 1, 2'b01, 1, 0, 0);
    add("step3", 0, 1, 1, 8'd0, 4'b0000, 1, 2'b10, 1, 1, 0);
    add("step4", 0, 1, 1, 8'd0, 4'b0000, 1, 2'b10, 1, 0, 0);
    add("step5", 0, 1, 1, 8'd0, 4'b0000, 1, 2'b11, 1, 1, 0);
    add("step6", 0, 1, 1, 8'd0, 4'b0000, 1, 2'b11, 1, 0, 0);
    add("step_hold1", 0, 1, 1, 8'd0, 4'b0000, 0, 2'b11, 1, 0, 0);
    add("step_hold2", 0, 1, 1, 8'd0, 4'b0000, 0, 2'b11, 1, 0, 0);

    foreach (vq[k]) begin
      drive(vq[k].rst, vq[k].en, vq[k].mode, vq[k].dwell,
            vq[k].mask, vq[k].req);
      expect_out(vq[k].name, vq[k].s, vq[k].v, vq[k].a, vq[k].f);
    end

    // live mask change: STEP@11 -> SCAN, walk to line 2
    drive(0, 1, 0, 8'd0, 4'b0000, 0);
    expect_out("mode_sw", 2'b11, 1, 0, 0);
    drive(0, 1, 0, 8'd0, 4'b0000, 0);
    expect_out("lm_wrap", 2'b00, 1, 0, 1);
    drive(0, 1, 0, 8'd0, 4'b0000, 0);
    expect_out("lm_01", 2'b01, 1, 0, 0);
    drive(0, 1, 0, 8'd0, 4'b0000, 0);
    expect_out("lm_10", 2'b10, 1, 0, 0);
    drive(0, 1, 0, 8'd7, 4'b0000, 0);
    expect_out("lm_dwell", 2'b10, 1, 0, 0);
    drive(0, 1, 0, 8'd7, 4'b0100, 0);
    expect_out("lm_force", 2'b11, 1, 0, 0);
    drive(0, 1, 0, 8'd7, 4'b0100, 0);
    expect_out("lm_hold", 2'b11, 1, 0, 0);
    drive(0, 1, 0, 8'd7, 4'b1111, 0);
    expect_out("lm_allmask", 2'b11, 0, 0, 0);
    drive(0, 1, 0, 8'd7, 4'b1111, 0);
    expect_out("lm_idle", 2'b11, 0, 0, 0);

    // disable and reset in STEP
    drive(0, 1, 1, 8'd0, 4'b0000, 0);
    expect_out("dr_entry", 2'b00, 1, 0, 0);
    drive(0, 1, 1, 8'd0, 4'b0000, 1);
    expect_out("dr_step", 2'b01, 1, 1, 0);
    drive(0, 1, 1, 8'd0, 4'b0000, 0);
    expect_out("dr_quiet", 2'b01, 1, 0, 0);
    drive(0, 0, 1, 8'd0, 4'b0000, 1);
    expect_out("dr_disable", 2'b01, 0, 0, 0);
    drive(0, 1, 1, 8'd0, 4'b0000, 0);
    expect_out("dr_restart", 2'b00, 1, 0, 0);
    drive(0, 1, 1, 8'd0, 4'b0000, 1);
    expect_out("dr_step2", 2'b01, 1, 1, 0);
    drive(0, 1, 1, 8'd0, 4'b0000, 0);
    expect_out("dr_quiet2", 2'b01, 1, 0, 0);
    drive(1, 1, 1, 8'd0, 4'b0000, 1);
    expect_out("dr_rst", 2'b00, 0, 0, 0);

    // single unmasked line
    drive(0, 1, 0, 8'd1, 4'b1101, 0);
    expect_out("one_entry", 2'b01, 1, 0, 0);
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 0, 8'd1, 4'b1101, 0);
      expect_out("one_line", 2'b01, 1, 0, logic'(i % 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
